// File: rtl/cla_multiword_add_seq.sv
// cla_multiword_add_seq: adds two WORDS*16-bit operands one 16-bit slice per cycle through an external CLA16.
// Optional subtract support (op_sub port) is enabled by defining CLA_SEQ_SUB_MODE_EN.
module cla_multiword_add_seq #(
   parameter  int WORDS = 4,
   localparam int W     = 16 * WORDS,
   localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic         clk,
   input  logic         rst,
`ifdef CLA_SEQ_SUB_MODE_EN
   input  logic         op_sub,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         op_cin,
   output logic [15:0]  add_a,
   output logic [15:0]  add_b,
   output logic         add_cin,
   input  logic [15:0]  add_s,
   input  logic         add_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q,   idx_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  a_q,     a_d;
   logic [W-1:0]  b_q,     b_d;
   logic [W-1:0]  sum_q,   sum_d;
   logic          cout_q,  cout_d;
   logic          sub_q,   sub_d;
   logic          sub_in;
   logic [15:0]   b_slice;

`ifdef CLA_SEQ_SUB_MODE_EN
   assign sub_in = op_sub;
`else
   assign sub_in = 1'b0;
`endif

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

   // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      sub_d   = sub_q;
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      b_slice = b_q[16*idx_q +: 16];

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               sub_d   = sub_in;
               // Subtraction is A + ~B + 1, so the incoming carry is forced high.
               carry_d = sub_in ? 1'b1 : op_cin;
               idx_d   = '0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            add_a   = a_q[16*idx_q +: 16];
            add_b   = sub_q ? ~b_slice : b_slice;
            add_cin = carry_q;
            sum_d[16*idx_q +: 16] = add_s;
            carry_d = add_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_cout;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         sub_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         sub_q   <= sub_d;
      end
   end

endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// Self-checking bench for cla_multiword_add_seq (WORDS=4) with a behavioural CLA16 and a wide-arithmetic reference model.
module tb_cla_multiword_add_seq;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         op_sub = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         op_cin = 1'b0;
   logic [15:0]  add_a, add_b, add_s;
   logic         add_cin, add_cout;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // External CLA16 stand-in: plain 16-bit addition with carry.
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

   cla_multiword_add_seq #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef CLA_SEQ_SUB_MODE_EN
      .op_sub    (op_sub),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_cin    (op_cin),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: whole-operand arithmetic, 65-bit result {cout, sum}.
   function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
      logic [W-1:0] nb;
      nb = ~b;
      if (sub) ref_result = {1'b0, a} + {1'b0, nb} + (W+1)'(1);
      else     ref_result = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input int hold, input logic pulse_in);
      logic [W:0] exp;
      int n;
      op_sub = sub;
      exp    = ref_result(a, b, cin, op_sub);
      op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
      check("in_ready_idle", in_ready, 1);
      check("out_valid_idle", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("first_slice_a", add_a, a[15:0]);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", n, WORDS);
      check("in_ready_done", in_ready, 0);
      check("add_a_done", add_a, 0);
      check("sum", sum, exp[W-1:0]);
      check("cout", cout, exp[W]);
      for (int i = 0; i < hold; i++) begin
         if (pulse_in) begin
            op_a = ~a; op_b = ~b; op_cin = ~cin; in_valid = (i % 2 == 0);
         end
         @(posedge clk); #1;
         check("hold_sum", sum, exp[W-1:0]);
         check("hold_cout", cout, exp[W]);
         check("hold_in_ready", in_ready, 0);
         check("hold_out_valid", out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_out_valid", out_valid, 0);
      check("release_in_ready", in_ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] ra, rb;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_add_cin", add_cin, 0);

      run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b0);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, 1'b0);
      run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 5, 1'b1);

      // Abort mid-operation with idx=2.
      op_a = 64'hAAAA_BBBB_CCCC_DDDD; op_b = 64'h1111_2222_3333_4444; op_cin = 1'b0;
      op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_add_a_idx2", add_a, 16'hBBBB);
      check("mid_add_b_idx2", add_b, 16'h2222);
      #2 rst = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_sum", sum, 0);
      check("abort_cout", cout, 0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      check("abort_stays_idle", out_valid, 0);
      run_op(64'h8000_0000_0000_0001, 64'h8000_0000_0000_FFFF, 1'b1, 1'b0, 1, 1'b0);

`ifdef CLA_SEQ_SUB_MODE_EN
      run_op(64'd5, 64'd7, 1'b0, 1'b1, 0, 1'b0);
      run_op(64'd7, 64'd5, 1'b0, 1'b1, 0, 1'b0);
      run_op(64'd9, 64'd9, 1'b0, 1'b1, 0, 1'b0);
`endif

      for (int k = 0; k < 24; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (k % 6 == 0) rb = ~ra;
`ifdef CLA_SEQ_SUB_MODE_EN
         run_op(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b0);
`else
         run_op(ra, rb, 1'($urandom), 1'b0, $urandom_range(0, 2), 1'b0);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
